// File: rtl/ftoi_if.sv
// Valid/ready stream bundle for the float-to-int converter: binary32 operand in, int32 result out.
interface ftoi_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_ovf;
  logic        out_inexact;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_ovf, out_inexact
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_ovf, out_inexact
  );
endinterface

// File: rtl/ftoi.sv
// Pipelined binary32 -> int32 converter: operand capture, decode, shift, round/sign/saturate.
// Define FTOI_RNE_EN for round-to-nearest-even; otherwise the result truncates toward zero.
module ftoi (
  input  logic   clk,
  input  logic   rst,
  ftoi_if.slave  bus
);

  typedef enum logic [2:0] {
    CLS_NORMAL,
    CLS_SMALL,
    CLS_BIG,
    CLS_INF,
    CLS_NAN,
    CLS_MININT
  } cls_e;

  logic        adv;

  logic        op_valid_q;
  logic [31:0] op_q;

  logic        s1_valid_q;
  logic        s1_sign_q,  s1_sign_d;
  logic [7:0]  s1_exp_q,   s1_exp_d;
  logic [23:0] s1_sig_q,   s1_sig_d;
  cls_e        s1_cls_q,   s1_cls_d;

  logic        s2_valid_q;
  logic        s2_sign_q;
  cls_e        s2_cls_q;
  logic [31:0] s2_int_q,    s2_int_d;
  logic        s2_guard_q,  s2_guard_d;
  logic        s2_sticky_q, s2_sticky_d;
  logic [4:0]  shamt;
  logic [55:0] fixed_mag;

  logic        out_valid_q;
  logic [31:0] out_data_q,    out_data_d;
  logic        out_ovf_q,     out_ovf_d;
  logic        out_inexact_q, out_inexact_d;
  logic        inc;
  logic [31:0] rnd_mag;

  // The whole pipeline moves as one; a stalled output freezes every stage.
  assign adv          = !out_valid_q || bus.out_ready;
  assign bus.in_ready = adv;

  // Decode: significand gets the hidden bit unless the operand is zero/denormal.
  always_comb begin
    s1_sign_d = op_q[31];
    s1_exp_d  = op_q[30:23];
    s1_sig_d  = {(op_q[30:23] != 8'd0), op_q[22:0]};
    if (op_q[30:23] == 8'd255) begin
      s1_cls_d = (op_q[22:0] != 23'd0) ? CLS_NAN : CLS_INF;
    end else if (op_q[30:23] >= 8'd158) begin
      // -2^31 is the only in-range value at this exponent.
      s1_cls_d = (op_q[31] && op_q[30:23] == 8'd158 && op_q[22:0] == 23'd0) ? CLS_MININT
                                                                            : CLS_BIG;
    end else if (op_q[30:23] < 8'd126) begin
      s1_cls_d = CLS_SMALL;
    end else begin
      s1_cls_d = CLS_NORMAL;
    end
  end

  assign shamt     = 5'(s1_exp_q - 8'd126);
  assign fixed_mag = {32'd0, s1_sig_q} << shamt;

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    s2_int_d    = 32'd0;
    s2_guard_d  = 1'b0;
    s2_sticky_d = 1'b0;
    unique case (s1_cls_q)
      CLS_NORMAL: begin
        s2_int_d    = fixed_mag[55:24];
        s2_guard_d  = fixed_mag[23];
        s2_sticky_d = |fixed_mag[22:0];
      end
      CLS_SMALL: begin
        s2_sticky_d = |s1_sig_q;
      end
      default: ;
    endcase
  end

  always_comb begin
`ifdef FTOI_RNE_EN
    inc = s2_guard_q & (s2_sticky_q | s2_int_q[0]);
`else
    inc = 1'b0;
`endif
    // Largest exponent-157 magnitude is 2^31-128, so the increment never carries out.
    rnd_mag       = s2_int_q + {31'd0, inc};
    out_data_d    = s2_sign_q ? -rnd_mag : rnd_mag;
    out_ovf_d     = 1'b0;
    out_inexact_d = s2_guard_q | s2_sticky_q;
    unique case (s2_cls_q)
      CLS_NAN: begin
        out_data_d    = 32'h8000_0000;
        out_ovf_d     = 1'b1;
        out_inexact_d = 1'b0;
      end
      CLS_INF, CLS_BIG: begin
        out_data_d    = s2_sign_q ? 32'h8000_0000 : 32'h7FFF_FFFF;
        out_ovf_d     = 1'b1;
        out_inexact_d = 1'b0;
      end
      CLS_MININT: begin
        out_data_d    = 32'h8000_0000;
        out_inexact_d = 1'b0;
      end
      default: ;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so all stages sample pre-edge values.
  // NOTE: datapath registers are reset as well, since the result port must read zero in reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_valid_q    <= 1'b0;
      op_q          <= 32'd0;
      s1_valid_q    <= 1'b0;
      s1_sign_q     <= 1'b0;
      s1_exp_q      <= 8'd0;
      s1_sig_q      <= 24'd0;
      s1_cls_q      <= CLS_SMALL;
      s2_valid_q    <= 1'b0;
      s2_sign_q     <= 1'b0;
      s2_cls_q      <= CLS_SMALL;
      s2_int_q      <= 32'd0;
      s2_guard_q    <= 1'b0;
      s2_sticky_q   <= 1'b0;
      out_valid_q   <= 1'b0;
      out_data_q    <= 32'd0;
      out_ovf_q     <= 1'b0;
      out_inexact_q <= 1'b0;
    end else if (adv) begin
      op_valid_q    <= bus.in_valid;
      op_q          <= bus.in_data;
      s1_valid_q    <= op_valid_q;
      s1_sign_q     <= s1_sign_d;
      s1_exp_q      <= s1_exp_d;
      s1_sig_q      <= s1_sig_d;
      s1_cls_q      <= s1_cls_d;
      s2_valid_q    <= s1_valid_q;
      s2_sign_q     <= s1_sign_q;
      s2_cls_q      <= s1_cls_q;
      s2_int_q      <= s2_int_d;
      s2_guard_q    <= s2_guard_d;
      s2_sticky_q   <= s2_sticky_d;
      out_valid_q   <= s2_valid_q;
      out_data_q    <= out_data_d;
      out_ovf_q     <= out_ovf_d;
      out_inexact_q <= out_inexact_d;
    end
  end

  assign bus.out_valid   = out_valid_q;
  assign bus.out_data    = out_data_q;
  assign bus.out_ovf     = out_ovf_q;
  assign bus.out_inexact = out_inexact_q;

endmodule
